immediate_field_encoder: RTL and testbench

IMMEDIATE_FIELD_ENCODER -- requirements
Module: immediate_field_encoder

---
 rtl/immediate_field_encoder.sv | 172 +++++++++++++++++
 tb/tb_immediate_field_encoder.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/immediate_field_encoder.sv
// Compresses a byte value/offset into a selectable instruction immediate field and queues
// results in a 2-entry in-order buffer. Optional error counter: define IMMENC_ERRCNT_EN.
module immediate_field_encoder (
    input  logic        Clk,
    input  logic        Clr,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_value,
    input  logic [31:0] in_tmpl,
    input  logic [2:0]  in_sel,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_word,
    output logic        out_err,
    output logic [1:0]  out_code,
    output logic [15:0] err_count
);

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_ONE   = 2'd1,
        S_TWO   = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        C_OK       = 2'd0,
        C_RANGE    = 2'd1,
        C_MISALIGN = 2'd2,
        C_ILLEGAL  = 2'd3
    } code_e;

    typedef struct packed {
        logic [31:0] word;
        logic        err;
        code_e       code;
    } entry_t;

    state_e state_q;
    entry_t head_q;
    entry_t tail_q;
    entry_t enc_d;

    logic push;
    logic pop;

    logic [31:0] field_mask;
    logic [31:0] field_val;
    logic        overflow;
    logic        misaligned;
    logic        illegal;

    // True when every bit of the slice is a copy of the sign, i.e. the value sign-extends.
    function automatic logic all_same(input logic [31:0] bits, input int unsigned lsb);
        logic [31:0] mask;
        mask = 32'hFFFF_FFFF << lsb;
        return ((bits & mask) == mask) || ((bits & mask) == 32'h0);
    endfunction

    // NOTE: every signal written in always_comb gets a default first so no path leaves it
    // unassigned; a missing default infers a latch.
    always_comb begin
        field_mask = 32'h0;
        field_val  = 32'h0;
        overflow   = 1'b0;
        misaligned = 1'b0;
        illegal    = 1'b0;
        case (in_sel)
            3'd0: begin
                field_mask = 32'h0000_1FFF;
                field_val  = {19'h0, in_value[12:0]};
                overflow   = !all_same(in_value, 12);
            end
            3'd1: begin
                field_mask = 32'h003F_FFFF;
                field_val  = {10'h0, in_value[21:0]};
                overflow   = !all_same(in_value, 21);
            end
            3'd2: begin
                field_mask = 32'h3FFF_FFFF;
                field_val  = {2'h0, in_value[29:0]};
                overflow   = !all_same(in_value, 29);
            end
            3'd3: begin
                field_mask = 32'h3FFF_FFFF;
                field_val  = {2'h0, in_value[31:2]};
                misaligned = |in_value[1:0];
            end
            3'd4: begin
                field_mask = 32'h003F_FFFF;
                field_val  = {10'h0, in_value[21:0]};
                overflow   = |in_value[31:22];
            end
            3'd5: begin
                field_mask = 32'h003F_FFFF;
                field_val  = {10'h0, in_value[23:2]};
                misaligned = |in_value[1:0];
                overflow   = !all_same(in_value, 23);
            end
            default: illegal = 1'b1;
        endcase

        if (illegal)         enc_d.code = C_ILLEGAL;
        else if (misaligned) enc_d.code = C_MISALIGN;
        else if (overflow)   enc_d.code = C_RANGE;
        else                 enc_d.code = C_OK;
        enc_d.err  = (enc_d.code != C_OK);
        // Illegal selects carry an all-zero mask, so the template passes through untouched.
        enc_d.word = (in_tmpl & ~field_mask) | (enc_d.err ? 32'h0 : field_val);
    end

    assign in_ready  = (state_q != S_TWO);
    assign out_valid = (state_q != S_EMPTY);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    assign out_word = head_q.word;
    assign out_err  = head_q.err;
    assign out_code = head_q.code;

    // NOTE: the two data entries are reset along with the state so out_* read zero during
    // reset and discarded entries never reappear; this buffer is tiny, so the cost is nil.
    always_ff @(posedge Clk or negedge Clr) begin
        if (!Clr) begin
            state_q <= S_EMPTY;
            head_q  <= '0;
            tail_q  <= '0;
        end else begin
            case (state_q)
                S_EMPTY: begin
                    if (push) begin
                        head_q  <= enc_d;
                        state_q <= S_ONE;
                    end
                end
                S_ONE: begin
                    if (push && pop) begin
                        head_q <= enc_d;
                    end else if (push) begin
                        tail_q  <= enc_d;
                        state_q <= S_TWO;
                    end else if (pop) begin
                        state_q <= S_EMPTY;
                    end
                end
                S_TWO: begin
                    if (pop) begin
                        head_q  <= tail_q;
                        state_q <= S_ONE;
                    end
                end
                default: state_q <= S_EMPTY;
            endcase
        end
    end

`ifdef IMMENC_ERRCNT_EN
    logic [15:0] err_cnt_q;

    always_ff @(posedge Clk or negedge Clr) begin
        if (!Clr) begin
            err_cnt_q <= 16'h0;
        end else if (push && enc_d.err && (err_cnt_q != 16'hFFFF)) begin
            err_cnt_q <= err_cnt_q + 16'h1;
        end
    end

    assign err_count = err_cnt_q;
`else
    assign err_count = 16'h0;
`endif

endmodule

// File: tb/tb_immediate_field_encoder.sv
// Directed-vector bench for immediate_field_encoder; err_count expectations follow
// whether IMMENC_ERRCNT_EN is defined.
module tb_immediate_field_encoder;

    logic        Clk;
    logic        Clr;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_value;
    logic [31:0] in_tmpl;
    logic [2:0]  in_sel;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_word;
    logic        out_err;
    logic [1:0]  out_code;
    logic [15:0] err_count;

    int checks   = 0;
    int failures = 0;
    int err_pushes = 0;

    immediate_field_encoder dut (
        .Clk       (Clk),
        .Clr       (Clr),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_value  (in_value),
        .in_tmpl   (in_tmpl),
        .in_sel    (in_sel),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_word  (out_word),
        .out_err   (out_err),
        .out_code  (out_code),
        .err_count (err_count)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] exp_cnt(input int n);
`ifdef IMMENC_ERRCNT_EN
        return (n > 65535) ? 32'hFFFF : 32'(n);
`else
        return 32'(n - n);
`endif
    endfunction

    // Drives one request, waits (bounded) for acceptance, and checks the result one cycle
    // later; out_ready is expected high so the result is the head of the buffer.
    task automatic do_push(input string tag, input logic [2:0] sel, input logic [31:0] v,
                           input logic [31:0] tmpl, input logic [31:0] exp_word,
                           input logic [1:0] exp_code);
        int waited;
        in_valid = 1'b1;
        in_sel   = sel;
        in_value = v;
        in_tmpl  = tmpl;
        waited   = 0;
        while (!in_ready && waited < 20) begin
            @(posedge Clk);
            #1;
            waited++;
        end
        if (waited >= 20) check({tag, "_ready_timeout"}, 32'(in_ready), 32'h1);
        @(posedge Clk);
        #1;
        in_valid = 1'b0;
        if (exp_code != 2'd0) err_pushes++;
        check({tag, "_valid"}, 32'(out_valid), 32'h1);
        check({tag, "_word"},  out_word, exp_word);
        check({tag, "_code"},  32'(out_code), 32'(exp_code));
        check({tag, "_err"},   32'(out_err), 32'(exp_code != 2'd0));
        check({tag, "_cnt"},   32'(err_count), exp_cnt(err_pushes));
    endtask

    initial begin
        Clr       = 1'b0;
        in_valid  = 1'b0;
        in_value  = '0;
        in_tmpl   = '0;
        in_sel    = '0;
        out_ready = 1'b1;

        #2;
        check("rst_valid", 32'(out_valid), 32'h0);
        check("rst_word",  out_word, 32'h0);
        check("rst_err",   32'(out_err), 32'h0);
        check("rst_code",  32'(out_code), 32'h0);
        check("rst_cnt",   32'(err_count), 32'h0);
        #20;
        Clr = 1'b1;
        @(posedge Clk);
        #1;
        check("post_rst_ready", 32'(in_ready), 32'h1);

        // Reference vectors and field boundaries.
        do_push("s0_fit",    3'd0, 32'hFFFF_F000, 32'h8000_2000, 32'h8000_3000, 2'd0);
        do_push("s0_ovf",    3'd0, 32'h0000_1000, 32'h8000_2000, 32'h8000_2000, 2'd1);
        do_push("s5_mis",    3'd5, 32'h0000_0006, 32'h1234_5678, 32'h1200_0000, 2'd2);
        do_push("s6_ill",    3'd6, 32'hDEAD_BEEF, 32'hCAFE_F00D, 32'hCAFE_F00D, 2'd3);
        do_push("s3_neg",    3'd3, 32'hFFFF_FFFC, 32'h4000_0000, 32'h7FFF_FFFF, 2'd0);
        do_push("s3_mis",    3'd3, 32'h0000_0002, 32'h4000_0000, 32'h4000_0000, 2'd2);
        do_push("s1_fit",    3'd1, 32'hFFE0_0000, 32'hFFFF_FFFF, 32'hFFE0_0000, 2'd0);
        do_push("s1_ovf",    3'd1, 32'h0020_0000, 32'hFFFF_FFFF, 32'hFFC0_0000, 2'd1);
        do_push("s2_fit",    3'd2, 32'h1FFF_FFFF, 32'h8000_0000, 32'h9FFF_FFFF, 2'd0);
        do_push("s2_ovf",    3'd2, 32'h2000_0000, 32'h8000_0000, 32'h8000_0000, 2'd1);
        do_push("s4_fit",    3'd4, 32'h003F_FFFF, 32'h00C0_0000, 32'h00FF_FFFF, 2'd0);
        do_push("s4_ovf",    3'd4, 32'h0040_0000, 32'h00C0_0000, 32'h00C0_0000, 2'd1);
        do_push("s5_fit",    3'd5, 32'hFFFF_FFFC, 32'h0000_0000, 32'h003F_FFFF, 2'd0);
        do_push("s5_ovf",    3'd5, 32'h0100_0000, 32'hFFFF_FFFF, 32'hFFC0_0000, 2'd1);
        do_push("s5_prio",   3'd5, 32'h0100_0001, 32'h0000_0000, 32'h0000_0000, 2'd2);
        do_push("s7_ill",    3'd7, 32'h0000_0003, 32'h0BAD_F00D, 32'h0BAD_F00D, 2'd3);
        do_push("s0_maxpos", 3'd0, 32'h0000_0FFF, 32'h0000_0000, 32'h0000_0FFF, 2'd0);
        do_push("s0_minneg", 3'd0, 32'hFFFF_EFFF, 32'hFFFF_FFFF, 32'hFFFF_E000, 2'd1);

        // Simultaneous push and pop in ONE: the second result follows with no bubble.
        do_push("b2b_a", 3'd0, 32'h0000_0011, 32'h0000_0000, 32'h0000_0011, 2'd0);
        do_push("b2b_b", 3'd0, 32'h0000_0022, 32'h0000_0000, 32'h0000_0022, 2'd0);
        @(posedge Clk);
        #1;
        check("drain_valid", 32'(out_valid), 32'h0);

        // Backpressure: two entries fill the buffer, a third request is refused.
        out_ready = 1'b0;
        in_valid = 1'b1; in_sel = 3'd0; in_tmpl = 32'h0; in_value = 32'h0000_0001;
        @(posedge Clk); #1;
        check("bp_ready1", 32'(in_ready), 32'h1);
        in_value = 32'h0000_0002;
        @(posedge Clk); #1;
        check("bp_ready2", 32'(in_ready), 32'h0);
        in_value = 32'h0000_0003;
        @(posedge Clk); #1;
        @(posedge Clk); #1;
        check("bp_hold_ready", 32'(in_ready), 32'h0);
        check("bp_hold_word",  out_word, 32'h0000_0001);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge Clk); #1;
        check("bp_second_word",  out_word, 32'h0000_0002);
        check("bp_second_valid", 32'(out_valid), 32'h1);
        check("bp_ready_back",   32'(in_ready), 32'h1);
        @(posedge Clk); #1;
        check("bp_empty", 32'(out_valid), 32'h0);

        // Reset while full discards both entries immediately.
        out_ready = 1'b0;
        in_valid = 1'b1; in_sel = 3'd6; in_tmpl = 32'h5555_AAAA; in_value = 32'h0;
        @(posedge Clk); #1;
        @(posedge Clk); #1;
        in_valid = 1'b0;
        err_pushes += 2;
        check("full_ready", 32'(in_ready), 32'h0);
        check("full_cnt",   32'(err_count), exp_cnt(err_pushes));
        #2;
        Clr = 1'b0;
        #1;
        check("clr_valid", 32'(out_valid), 32'h0);
        check("clr_word",  out_word, 32'h0);
        check("clr_code",  32'(out_code), 32'h0);
        check("clr_cnt",   32'(err_count), 32'h0);
        err_pushes = 0;
        @(negedge Clk);
        Clr = 1'b1;
        out_ready = 1'b1;
        @(posedge Clk); #1;
        check("clr_after_ready", 32'(in_ready), 32'h1);
        check("clr_after_valid", 32'(out_valid), 32'h0);

`ifdef IMMENC_ERRCNT_EN
        // Drive more failing pushes than the counter can hold.
        in_valid = 1'b1; in_sel = 3'd7; in_tmpl = 32'h0; in_value = 32'h0;
        for (int i = 0; i < 65540; i++) begin
            @(posedge Clk);
        end
        #1;
        in_valid = 1'b0;
        check("cnt_saturate", 32'(err_count), 32'hFFFF);
        @(posedge Clk); #1;
        check("cnt_hold", 32'(err_count), 32'hFFFF);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
